// File: rtl/asic_unlock_seq.sv
// Plus-ASIC lock/unlock sequence detector: snoops CPU I/O writes to the CRTC-select page,
// tracks sync + sequence + key, and drives the ASIC page unlock plus relock/timeout pulses.
module asic_unlock_seq #(
  parameter int                   SEQ_LEN    = 13,
  parameter logic [SEQ_LEN*8-1:0] SEQ        = 104'hFF77B351A8D46239_9C462B158A,
  parameter logic [7:0]           UNLOCK_KEY = 8'hCD,
  parameter logic [7:0]           ADDR_HI    = 8'hBC,
  parameter int                   TIMEOUT    = 0,
  parameter int                   CNT_W      = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             enable,
  input  logic [15:0]      cpu_addr,
  input  logic [7:0]       cpu_data_in,
  input  logic             cpu_wr,
  output logic             unlocked,
  output logic             unlock_pulse,
  output logic             lock_pulse,
  output logic             timeout_pulse,
  output logic [4:0]       seq_pos,
  output logic [CNT_W-1:0] key_cnt
);

  localparam int               TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [4:0]       LAST_IDX = 5'(SEQ_LEN - 1);
  localparam logic [4:0]       KEY_POS  = 5'(SEQ_LEN + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_MATCH = 2'd2,
    S_KEY   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [4:0]       pos_q, pos_d;
  logic             unlocked_q, unlocked_d;
  logic             unlock_pulse_q, unlock_pulse_d;
  logic             lock_pulse_q, lock_pulse_d;
  logic             timeout_pulse_q, timeout_pulse_d;
  logic [CNT_W-1:0] key_cnt_q, key_cnt_d;
  logic [TO_W-1:0]  tmo_q, tmo_d;
  logic             wr_q, wr_d;
  logic             ev;
  logic             addr_lo_unused;

  // Byte i of the sequence, byte 0 held in the MSBs.
  function automatic logic [7:0] seq_byte(input logic [4:0] i);
    logic [SEQ_LEN*8-1:0] sh;
    sh = SEQ << {i, 3'b000};
    return sh[SEQ_LEN*8-1 -: 8];
  endfunction

  assign addr_lo_unused = ^cpu_addr[7:0];
  assign wr_d = cpu_wr;
  // One event per strobe: only the rising edge of the write level qualifies.
  assign ev   = enable & cpu_wr & ~wr_q & (cpu_addr[15:8] == ADDR_HI);

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    unlocked_d      = unlocked_q;
    unlock_pulse_d  = 1'b0;
    lock_pulse_d    = 1'b0;
    timeout_pulse_d = 1'b0;
    key_cnt_d       = key_cnt_q;
    tmo_d           = tmo_q;
    pos_d           = pos_q;

    if (!enable) begin
      state_d    = S_IDLE;
      idx_d      = 5'd0;
      unlocked_d = 1'b0;
      tmo_d      = {TO_W{1'b0}};
    end else if (ev) begin
      tmo_d = {TO_W{1'b0}};
      case (state_q)
        S_IDLE: begin
          state_d = (cpu_data_in != 8'h00) ? S_ARMED : S_IDLE;
        end
        S_ARMED: begin
          if (cpu_data_in == 8'h00) begin
            state_d = S_MATCH;
            idx_d   = 5'd0;
          end else begin
            state_d = S_ARMED;
          end
        end
        S_MATCH: begin
          if (cpu_data_in == seq_byte(idx_q)) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_KEY;
              idx_d   = 5'd0;
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end else if (cpu_data_in != 8'h00) begin
            state_d = S_ARMED;
            idx_d   = 5'd0;
          end else if (idx_q != 5'd0) begin
            idx_d = 5'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_KEY: begin
          if (cpu_data_in == UNLOCK_KEY) begin
            unlocked_d     = 1'b1;
            unlock_pulse_d = 1'b1;
          end else begin
            unlocked_d   = 1'b0;
            lock_pulse_d = 1'b1;
          end
          if (key_cnt_q != {CNT_W{1'b1}}) begin
            key_cnt_d = key_cnt_q + CNT_W'(1);
          end else begin
            key_cnt_d = key_cnt_q;
          end
          state_d = (cpu_data_in != 8'h00) ? S_ARMED : S_IDLE;
          idx_d   = 5'd0;
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = 5'd0;
        end
      endcase
    end else if ((TIMEOUT > 0) && (state_q != S_IDLE)) begin
      // Idle gap mid-sequence: abort once TIMEOUT cycles pass with no event.
      if (tmo_q == TO_LAST) begin
        state_d         = S_IDLE;
        idx_d           = 5'd0;
        tmo_d           = {TO_W{1'b0}};
        timeout_pulse_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TO_W'(1);
      end
    end else begin
      tmo_d = {TO_W{1'b0}};
    end

    case (state_d)
      S_IDLE:  pos_d = 5'd0;
      S_ARMED: pos_d = 5'd1;
      S_MATCH: pos_d = 5'd2 + idx_d;
      S_KEY:   pos_d = KEY_POS;
      default: pos_d = 5'd0;
    endcase
  end

  // All state and registered outputs.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      idx_q           <= 5'd0;
      pos_q           <= 5'd0;
      unlocked_q      <= 1'b0;
      unlock_pulse_q  <= 1'b0;
      lock_pulse_q    <= 1'b0;
      timeout_pulse_q <= 1'b0;
      key_cnt_q       <= {CNT_W{1'b0}};
      tmo_q           <= {TO_W{1'b0}};
      wr_q            <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      pos_q           <= pos_d;
      unlocked_q      <= unlocked_d;
      unlock_pulse_q  <= unlock_pulse_d;
      lock_pulse_q    <= lock_pulse_d;
      timeout_pulse_q <= timeout_pulse_d;
      key_cnt_q       <= key_cnt_d;
      tmo_q           <= tmo_d;
      wr_q            <= wr_d;
    end
  end

  assign unlocked      = unlocked_q;
  assign unlock_pulse  = unlock_pulse_q;
  assign lock_pulse    = lock_pulse_q;
  assign timeout_pulse = timeout_pulse_q;
  assign seq_pos       = pos_q;
  assign key_cnt       = key_cnt_q;

endmodule

// File: tb/tb_asic_unlock_seq.sv
// Scoreboard bench for asic_unlock_seq: a driver feeds writes and pushes the reference model's
// expected outputs per cycle; a monitor pops and compares one entry after every clock edge.
module tb_asic_unlock_seq;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset, enable, cpu_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        unlocked, unlock_pulse, lock_pulse, timeout_pulse;
  logic [4:0]  seq_pos;
  logic [7:0]  key_cnt;

  always #5 clk = ~clk;

  asic_unlock_seq #(.TIMEOUT(TMO)) dut (
    .clk_sys(clk), .reset(reset), .enable(enable), .cpu_addr(cpu_addr),
    .cpu_data_in(cpu_data_in), .cpu_wr(cpu_wr), .unlocked(unlocked),
    .unlock_pulse(unlock_pulse), .lock_pulse(lock_pulse), .timeout_pulse(timeout_pulse),
    .seq_pos(seq_pos), .key_cnt(key_cnt)
  );

  typedef struct packed {
    logic       unl;
    logic       up;
    logic       lp;
    logic       tp;
    logic [4:0] pos;
    logic [7:0] kc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  byte unsigned seq_b [13] = '{8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62,
                               8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A};

  // Reference model: pos 0 idle, 1 armed, 2..14 matched-so-far, 15 awaiting key.
  int m_pos, m_tmo, m_kc;
  bit m_unl, m_wrq;

  task automatic step(input bit rst, input bit en, input bit wr,
                      input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    bit   ev;
    int   i;
    @(negedge clk);
    reset = rst; enable = en; cpu_wr = wr; cpu_addr = a; cpu_data_in = d;
    e = '0;
    if (rst) begin
      m_pos = 0; m_tmo = 0; m_kc = 0; m_unl = 0; m_wrq = 0;
    end else begin
      ev = en && wr && !m_wrq && (a[15:8] == 8'hBC);
      if (!en) begin
        m_pos = 0; m_unl = 0; m_tmo = 0;
      end else if (ev) begin
        m_tmo = 0;
        if (m_pos == 0) begin
          m_pos = (d != 0) ? 1 : 0;
        end else if (m_pos == 1) begin
          m_pos = (d == 0) ? 2 : 1;
        end else if (m_pos == 15) begin
          m_unl = (d == 8'hCD);
          e.up  = m_unl;
          e.lp  = !m_unl;
          if (m_kc < 255) m_kc++;
          m_pos = (d != 0) ? 1 : 0;
        end else begin
          i = m_pos - 2;
          if (d == seq_b[i])  m_pos = m_pos + 1;
          else if (d != 0)    m_pos = 1;
          else if (i > 0)     m_pos = 2;
          else                m_pos = 0;
        end
      end else if (m_pos != 0) begin
        m_tmo++;
        if (m_tmo == TMO) begin
          m_pos = 0; m_tmo = 0; e.tp = 1'b1;
        end
      end else begin
        m_tmo = 0;
      end
      m_wrq = wr;
    end
    e.unl = m_unl;
    e.pos = 5'(m_pos);
    e.kc  = 8'(m_kc);
    exp_q.push_back(e);
  endtask

  task automatic wr_byte(input logic [15:0] a, input logic [7:0] d, input int hold, input int gap);
    for (int k = 0; k < hold; k++) step(1'b0, 1'b1, 1'b1, a, d);
    for (int k = 0; k < gap; k++)  step(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic send_seq(input logic [7:0] key);
    wr_byte(16'hBC00, 8'h01, 1, 1);
    wr_byte(16'hBC00, 8'h00, 1, 1);
    for (int k = 0; k < 13; k++) wr_byte(16'hBC00, seq_b[k], 1, 1);
    wr_byte(16'hBC00, key, 1, 1);
  endtask

  // Randomised write: random hold, mostly short gaps, occasionally a gap near the timeout.
  task automatic rwr(input logic [7:0] d);
    logic [15:0] a;
    int          gap;
    a   = ($urandom_range(0, 9) == 0) ? 16'($urandom) : {8'hBC, 8'($urandom)};
    gap = ($urandom_range(0, 29) == 0) ? $urandom_range(14, 18) : $urandom_range(1, 3);
    wr_byte(a, d, $urandom_range(1, 3), gap);
  endtask

  exp_t       em;
  logic [16:0] gm;

  // Monitor: one expected entry per clock edge.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      em = exp_q.pop_front();
      gm = {unlocked, unlock_pulse, lock_pulse, timeout_pulse, seq_pos, key_cnt};
      n_checks++;
      if (gm !== em) begin
        n_fail++;
        $display("FAIL outputs t=%0t got unl=%b up=%b lp=%b tp=%b pos=%0d kc=%0d exp unl=%b up=%b lp=%b tp=%b pos=%0d kc=%0d",
                 $time, gm[16], gm[15], gm[14], gm[13], gm[12:8], gm[7:0],
                 em.unl, em.up, em.lp, em.tp, em.pos, em.kc);
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_data_in = 8'h00;
    repeat (3) step(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);

    // Unlock, relock with key 00, then mismatch with resync.
    wr_byte(16'hBC00, 8'h00, 1, 1);
    send_seq(8'hCD);
    idle(2);
    wr_byte(16'hBC00, 8'h00, 1, 1);
    for (int k = 0; k < 13; k++) wr_byte(16'hBC00, seq_b[k], 1, 1);
    wr_byte(16'hBC00, 8'h00, 1, 1);
    wr_byte(16'hBC00, 8'h01, 1, 1);
    wr_byte(16'hBC00, 8'h00, 1, 1);
    wr_byte(16'hBC00, 8'hFF, 1, 1);
    wr_byte(16'hBC00, 8'h77, 1, 1);
    wr_byte(16'hBC00, 8'hB4, 1, 1);
    wr_byte(16'hBC00, 8'h00, 1, 1);
    for (int k = 0; k < 13; k++) wr_byte(16'hBC00, seq_b[k], 1, 1);
    wr_byte(16'hBC00, 8'hCD, 1, 1);

    // Long strobe, foreign ports and reads.
    wr_byte(16'hBC00, 8'h00, 10, 2);
    wr_byte(16'hBD00, 8'hFF, 1, 1);
    wr_byte(16'h7F00, 8'hFF, 1, 1);
    step(1'b0, 1'b1, 1'b0, 16'hBC00, 8'hFF);

    // Timeout after exactly TMO idle cycles, then an event landing on that cycle.
    wr_byte(16'hBC00, 8'hFF, 1, TMO);
    idle(2);
    wr_byte(16'hBC00, 8'h01, 1, 1);
    wr_byte(16'hBC00, 8'h00, 1, 1);
    wr_byte(16'hBC00, 8'hFF, 1, TMO - 1);
    wr_byte(16'hBC00, 8'h77, 1, 1);

    // Enable drop while unlocked; enable rising with the strobe already high.
    send_seq(8'hCD);
    step(1'b0, 1'b0, 1'b0, 16'hBC00, 8'h00);
    step(1'b0, 1'b0, 1'b1, 16'hBC00, 8'h01);
    step(1'b0, 1'b1, 1'b1, 16'hBC00, 8'h01);
    step(1'b0, 1'b1, 1'b0, 16'hBC00, 8'h01);

    // Async reset in MATCH(5) must clear outputs before any clock edge.
    wr_byte(16'hBC00, 8'h01, 1, 1);
    wr_byte(16'hBC00, 8'h00, 1, 1);
    for (int k = 0; k < 5; k++) wr_byte(16'hBC00, seq_b[k], 1, 1);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 8'h00);
    #1;
    n_checks++;
    if (seq_pos !== 5'd0 || unlocked !== 1'b0 || key_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset got pos=%0d unl=%b kc=%0d exp pos=0 unl=0 kc=0",
               seq_pos, unlocked, key_cnt);
    end
    step(1'b1, 1'b1, 1'b0, 16'h0000, 8'h00);

    // Randomised sequences with corrupted bytes, varied keys and enable drops.
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        for (int k = 0; k < $urandom_range(1, 3); k++)
          step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 16'hBC00, 8'($urandom));
      end
      rwr(8'($urandom_range(1, 255)));
      rwr(8'h00);
      for (int k = 0; k < 13; k++)
        rwr(($urandom_range(0, 9) == 0) ? 8'($urandom) : seq_b[k]);
      rwr(($urandom_range(0, 1) == 0) ? 8'hCD : 8'($urandom));
    end

    // Drive the key counter into saturation.
    for (int it = 0; it < 260; it++) send_seq(8'hCD);
    send_seq(8'h5A);
    idle(3);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending entries exp 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
